// File: rtl/expr_result_sink.sv
// expr_result_sink: consumes 30-bit expression-stage result words over a
// valid/ready handshake. Words are buffered in a small FIFO, then folded into a
// 32-bit rotate-XOR signature. The block reports done once the programmed
// number of words has been folded.
// Optional feature: define EXPR_SINK_LANE_CHECK_EN to enable the sticky
// lane-consistency check on popped words (lane_err).
module expr_result_sink #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [29:0]      in_data,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature,
  output logic [CNT_W-1:0] word_cnt,
  output logic             lane_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_acc;
  logic [31:0]      r_sig;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [OW-1:0]    r_occ;
  logic [29:0]      r_mem [DEPTH];

  logic             w_start_ok;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [29:0]      w_pop_word;
  logic [31:0]      w_sig_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Handshake, FIFO status and the signature fold of the head word
  always_comb begin
    w_start_ok = start && (r_state != StRun);
    w_full     = (r_occ == OW'(DEPTH));
    w_empty    = (r_occ == '0);
    // Depends only on registered state, never on in_valid.
    in_ready   = (r_state == StRun) && !w_full && (r_acc < r_len);
    w_push     = in_valid && in_ready;
    w_pop      = (r_state == StRun) && !w_empty && !hold;
    w_pop_word = r_mem[r_rptr];
    w_sig_nxt  = {r_sig[30:0], r_sig[31]} ^ {2'b00, w_pop_word};
    w_cnt_inc  = r_cnt + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) w_state_nxt = (len == '0) ? StDone : StRun;
      end
      StRun: begin
        // Leave RUN on the edge that folds the final word so done and the
        // final signature become visible together.
        if ((w_pop && (w_cnt_inc == r_len)) || (r_cnt == r_len)) w_state_nxt = StDone;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Run bookkeeping: length, counters, FIFO pointers/occupancy and signature
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sig  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (w_start_ok) begin
      r_len  <= len;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sig  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
        r_acc  <= r_acc + CNT_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_sig  <= w_sig_nxt;
        r_cnt  <= w_cnt_inc;
      end
      if (w_push && !w_pop)      r_occ <= r_occ + OW'(1);
      else if (!w_push && w_pop) r_occ <= r_occ - OW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

`ifdef EXPR_SINK_LANE_CHECK_EN
  logic w_lane_bad;
  logic r_lane_err;

  // A word is bad if the pad bits are set or any lane differs from lane 0
  always_comb begin
    w_lane_bad = |w_pop_word[29:24];
    for (int i = 1; i < 6; i++) begin
      if (w_pop_word[i*4 +: 4] != w_pop_word[3:0]) w_lane_bad = 1'b1;
    end
  end

  // Sticky error flag, cleared by reset or an honoured start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_lane_err <= 1'b0;
    else if (w_start_ok)          r_lane_err <= 1'b0;
    else if (w_pop && w_lane_bad) r_lane_err <= 1'b1;
  end

  assign lane_err = r_lane_err;
`else
  assign lane_err = 1'b0;
`endif

  assign busy      = (r_state == StRun);
  assign done      = (r_state == StDone);
  assign signature = r_sig;
  assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_expr_result_sink.sv
// Directed self-checking bench for expr_result_sink (DEPTH=4, CNT_W=16).
module tb_expr_result_sink;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_data;
  logic        hold;
  logic        busy;
  logic        done;
  logic [31:0] signature;
  logic [15:0] word_cnt;
  logic        lane_err;

  int n_chk;
  int n_fail;

  expr_result_sink #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .word_cnt  (word_cnt),
    .lane_err  (lane_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] l);
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    int budget;
    logic acc;
    logic [29:0] words [6];

    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    hold     = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_sig",      signature,     32'd0);
    chk("rst_cnt",      32'(word_cnt), 32'd0);
    chk("rst_lane_err", 32'(lane_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single word
    do_start(16'd1);
    chk("t1_busy",  32'(busy),     32'd1);
    chk("t1_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 30'h0000001;
    tick();
    in_valid = 1'b0;
    chk("t1_ready_after_acc", 32'(in_ready), 32'd0);
    chk("t1_sig_before_pop",  signature,     32'd0);
    tick();
    chk("t1_sig",   signature,     32'h00000001);
    chk("t1_cnt",   32'(word_cnt), 32'd1);
    chk("t1_done",  32'(done),     32'd1);
    chk("t1_ready", 32'(in_ready), 32'd0);
    chk("t1_busy_end", 32'(busy),  32'd0);

    // Two words
    do_start(16'd2);
    chk("t2_done_cleared", 32'(done), 32'd0);
    in_valid = 1'b1;
    in_data  = 30'h0000001;
    tick();
    tick();
    in_valid = 1'b0;
    chk("t2_sig_mid", signature, 32'h00000001);
    tick();
    chk("t2_sig",  signature,     32'h00000003);
    chk("t2_cnt",  32'(word_cnt), 32'd2);
    chk("t2_done", 32'(done),     32'd1);

    // Backpressure: hold draining, only DEPTH words fit
    for (int i = 0; i < 6; i++) words[i] = 30'(i + 1);
    hold = 1'b1;
    do_start(16'd6);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (k < 6);
      in_data  = words[k % 6];
      acc      = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_accepted",  32'(k),        32'd4);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_cnt_held",  32'(word_cnt), 32'd0);
    chk("bp_sig_held",  signature,     32'd0);
    hold   = 1'b0;
    budget = 0;
    while (!done && budget < 40) begin
      in_valid = (k < 6);
      in_data  = words[k % 6];
      acc      = in_valid && in_ready;
      tick();
      if (acc) k++;
      budget++;
    end
    in_valid = 1'b0;
    chk("bp_timeout",   32'(done),     32'd1);
    chk("bp_accepted2", 32'(k),        32'd6);
    chk("bp_cnt",       32'(word_cnt), 32'd6);
    // 1,2,3,4,5,6 folded: 1 -> 0 -> 3 -> 2 -> 1 -> 4
    chk("bp_sig",       signature,     32'h00000004);

    // len == 0 goes straight to DONE
    do_start(16'd0);
    chk("l0_done",  32'(done),     32'd1);
    chk("l0_sig",   signature,     32'd0);
    chk("l0_ready", 32'(in_ready), 32'd0);
    tick();
    chk("l0_ready2", 32'(in_ready), 32'd0);
    chk("l0_busy",   32'(busy),     32'd0);

    // Reset in the middle of a run
    do_start(16'd4);
    in_valid = 1'b1;
    in_data  = 30'h0000007;
    tick();
    tick();
    in_valid = 1'b0;
    chk("mr_sig_before", signature, 32'h00000007);
    reset = 1'b1;
    #1;
    chk("mr_sig",   signature,     32'd0);
    chk("mr_cnt",   32'(word_cnt), 32'd0);
    chk("mr_busy",  32'(busy),     32'd0);
    chk("mr_ready", 32'(in_ready), 32'd0);
    chk("mr_done",  32'(done),     32'd0);
    #1;
    reset = 1'b0;
    tick();
    do_start(16'd1);
    in_valid = 1'b1;
    in_data  = 30'h0000005;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_new_sig",  signature,     32'h00000005);
    chk("mr_new_done", 32'(done),     32'd1);
    chk("mr_new_cnt",  32'(word_cnt), 32'd1);

    // Lane check: consistent word then inconsistent word
    do_start(16'd2);
    in_valid = 1'b1;
    in_data  = 30'h0FFFFFF;
    tick();
    in_data  = 30'h0FFFFFE;
    tick();
    in_valid = 1'b0;
    chk("lc_after_good", 32'(lane_err), 32'd0);
    tick();
`ifdef EXPR_SINK_LANE_CHECK_EN
    chk("lc_after_bad", 32'(lane_err), 32'd1);
    tick();
    chk("lc_sticky",    32'(lane_err), 32'd1);
`else
    chk("lc_after_bad", 32'(lane_err), 32'd0);
    tick();
    chk("lc_sticky",    32'(lane_err), 32'd0);
`endif
    // rot(0xFFFFFF) ^ 0xFFFFFE = 0x1FFFFFE ^ 0x0FFFFFE = 0x1000000
    chk("lc_sig",  signature,  32'h01000000);
    chk("lc_done", 32'(done),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
